// File: rtl/dmem_arbiter_if.sv
// Signal bundle joining the data-memory arbiter to the ME stage, the external port and the SRAM.
// The master modport is the environment side; the slave modport is the arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              enable;

  logic              cpu_req;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              ext_req;
  logic              ext_wen;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output enable,
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output ext_req, ext_wen, ext_addr, ext_wdata,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_addr, mem_wen, mem_ren, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  enable,
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  ext_req, ext_wen, ext_addr, ext_wdata,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_addr, mem_wen, mem_ren, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter: CPU ME stage has priority, the external port is forced through
// after MAX_WAIT consecutive denied cycles. Read data is routed back to whoever issued the read.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StPriCpu, StPriExt} state_e;

  localparam logic [3:0] WaitLast = 4'(MAX_WAIT - 1);
  localparam logic [3:0] WaitSat  = 4'hF;

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_pend_q;
  logic       rd_ext_q;

  logic c_req;
  logic cpu_win;
  logic ext_win;

  assign c_req = bus.cpu_req & bus.enable;

  // Grant decision: the priority state only picks who wins a collision.
  always_comb begin
    cpu_win = 1'b0;
    ext_win = 1'b0;
    unique case (state_q)
      StPriCpu: begin
        cpu_win = c_req;
        ext_win = bus.ext_req & ~c_req;
      end
      StPriExt: begin
        ext_win = bus.ext_req;
        cpu_win = c_req & ~bus.ext_req;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_ren   = 1'b0;
    bus.mem_wdata = '0;
    if (cpu_win) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wen   = bus.cpu_wen;
      bus.mem_ren   = ~bus.cpu_wen;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (ext_win) begin
      bus.mem_addr  = bus.ext_addr;
      bus.mem_wen   = bus.ext_wen;
      bus.mem_ren   = ~bus.ext_wen;
      bus.mem_wdata = bus.ext_wdata;
    end
  end

  assign bus.ext_gnt   = ext_win;
  assign bus.cpu_stall = c_req & ~cpu_win;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StPriCpu: begin
        if (c_req && bus.ext_req) begin
          if (wait_cnt_q != WaitSat) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
          if (wait_cnt_q == WaitLast) begin
            state_d = StPriExt;
          end
        end
      end
      StPriExt: begin
        // Forced slot lasts one cycle whether it was used or abandoned.
        if (ext_win || !bus.ext_req) begin
          state_d    = StPriCpu;
          wait_cnt_d = 4'd0;
        end
      end
      default: state_d = StPriCpu;
    endcase
    if (ext_win) begin
      wait_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StPriCpu;
      wait_cnt_q <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_ext_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= bus.mem_ren;
      rd_ext_q   <= ext_win;
    end
  end

  // Reset also squashes the response of a read issued just before it.
  assign bus.cpu_rvalid = rd_pend_q & ~rd_ext_q & ~rst;
  assign bus.ext_rvalid = rd_pend_q & rd_ext_q & ~rst;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.ext_rdata  = bus.ext_rvalid ? bus.mem_rdata : '0;

  assert property (@(posedge clk) disable iff (rst) !(cpu_win && ext_win));
  assert property (@(posedge clk) disable iff (rst) !(bus.mem_wen && bus.mem_ren));
  assert property (@(posedge clk) disable iff (rst) wait_cnt_q <= 4'(MAX_WAIT));

endmodule
